// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package mem_pkg;

  localparam int unsigned LATENCY_MAX = 7;
  localparam int unsigned CNT_W       = $clog2(LATENCY_MAX + 1);

  // RV32 load/store size and sign codes
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_align.sv
// Combinational byte-lane alignment, load extension, store strobes and error decode.
module dmem_align
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 128,
  parameter int unsigned ADDR_W      = 32,
  localparam int unsigned IDX_W      = $clog2(DEPTH_BYTES),
  localparam int unsigned WIDX_W     = IDX_W - 2
) (
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [31:0]       rword_i,
  output logic [WIDX_W-1:0] widx_o,
  output logic [31:0]       rdata_o,
  output logic [3:0]        wstrb_o,
  output logic [31:0]       wword_o,
  output logic              err_o
);

  logic [1:0]  lane;
  logic [31:0] shifted;
  logic [31:0] ext;
  logic [3:0]  strb;
  logic        oor;
  logic        misal;
  logic        legal;

  always_comb begin
    lane    = addr_i[1:0];
    shifted = rword_i >> {lane, 3'b000};
    oor     = (addr_i >> IDX_W) != '0;
    misal   = 1'b0;
    legal   = 1'b1;
    ext     = '0;
    strb    = '0;
    // Unsigned variants exist only for loads
    case (funct3_i)
      F3_B: begin
        ext  = {{24{shifted[7]}}, shifted[7:0]};
        strb = 4'b0001 << lane;
      end
      F3_BU: begin
        ext   = {24'h0, shifted[7:0]};
        legal = !we_i;
      end
      F3_H: begin
        misal = addr_i[0];
        ext   = {{16{shifted[15]}}, shifted[15:0]};
        strb  = 4'b0011 << lane;
      end
      F3_HU: begin
        misal = addr_i[0];
        ext   = {16'h0, shifted[15:0]};
        legal = !we_i;
      end
      F3_W: begin
        misal = |lane;
        ext   = shifted;
        strb  = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
    err_o   = oor | misal | !legal;
    rdata_o = (err_o || we_i) ? '0 : ext;
    wstrb_o = (err_o || !we_i) ? '0 : strb;
    wword_o = wdata_i << {lane, 3'b000};
    widx_o  = addr_i[IDX_W-1:2];
  end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressed data memory with a fixed-latency load/store request/response port.
module dmem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 128,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DBG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  input  logic [DBG_AW-1:0] dbg_addr,
  output logic [31:0]       dbg_rdata
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_BYTES);
  localparam int unsigned WIDX_W = IDX_W - 2;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ready_q, resp_valid_q;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [7:0]         mem_q [DEPTH_BYTES];

  logic               accept;
  logic               sel_we;
  logic [2:0]         sel_f3;
  logic [ADDR_W-1:0]  sel_addr;
  logic [31:0]        sel_wdata;
  logic [WIDX_W-1:0]  widx;
  logic [31:0]        rword;
  logic [31:0]        al_rdata;
  logic [3:0]         al_wstrb;
  logic [31:0]        al_wword;
  logic               al_err;
  logic [WIDX_W-1:0]  dbg_widx;
  logic               dbg_ok;

  assign accept = req_valid && req_ready_q && (state_q == S_IDLE);

  // Live request drives the aligner while idle (store path), captured request afterwards (load path)
  always_comb begin
    sel_we    = we_q;
    sel_f3    = f3_q;
    sel_addr  = addr_q;
    sel_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      sel_we    = req_we;
      sel_f3    = req_funct3;
      sel_addr  = req_addr;
      sel_wdata = req_wdata;
    end
  end

  assign rword = {mem_q[{widx, 2'd3}], mem_q[{widx, 2'd2}],
                  mem_q[{widx, 2'd1}], mem_q[{widx, 2'd0}]};

  dmem_align #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .ADDR_W     (ADDR_W)
  ) u_align (
    .we_i    (sel_we),
    .funct3_i(sel_f3),
    .addr_i  (sel_addr),
    .wdata_i (sel_wdata),
    .rword_i (rword),
    .widx_o  (widx),
    .rdata_o (al_rdata),
    .wstrb_o (al_wstrb),
    .wword_o (al_wword),
    .err_o   (al_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q >= CNT_W'(LATENCY - 1)) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= (state_d == S_IDLE);
      resp_valid_q <= (state_d == S_RESP);
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Stores commit on acceptance; errored requests carry an all-zero strobe
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem_q[i] <= '0;
    end else if (accept) begin
      for (int b = 0; b < 4; b++) begin
        if (al_wstrb[b]) mem_q[{widx, 2'(b)}] <= al_wword[8*b +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_valid_q ? al_rdata : '0;
  assign resp_err   = resp_valid_q & al_err;

  assign dbg_widx  = WIDX_W'(dbg_addr);
  assign dbg_ok    = (32'(dbg_addr) >> WIDX_W) == 32'd0;
  assign dbg_rdata = dbg_ok ? {mem_q[{dbg_widx, 2'd3}], mem_q[{dbg_widx, 2'd2}],
                               mem_q[{dbg_widx, 2'd1}], mem_q[{dbg_widx, 2'd0}]} : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench: dut0 (LATENCY=2, 128 B) and dut1 (LATENCY=1, 64 B).
module tb_dmem_lsu;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0, e1;

  logic        req_valid0, req_ready0, req_we0, resp_valid0, resp_err0;
  logic [2:0]  req_funct30;
  logic [31:0] req_addr0, req_wdata0, resp_rdata0, dbg_rdata0;
  logic [4:0]  dbg_addr0;
  logic        req_valid1, req_ready1, req_we1, resp_valid1, resp_err1;
  logic [2:0]  req_funct31;
  logic [31:0] req_addr1, req_wdata1, resp_rdata1, dbg_rdata1;
  logic [4:0]  dbg_addr1;
  int          acc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_lsu #(.DEPTH_BYTES(128), .ADDR_W(32), .LATENCY(2), .DBG_AW(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we0), .req_funct3(req_funct30), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .dbg_addr(dbg_addr0), .dbg_rdata(dbg_rdata0));

  dmem_lsu #(.DEPTH_BYTES(64), .ADDR_W(32), .LATENCY(1), .DBG_AW(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we1), .req_funct3(req_funct31), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
    .dbg_addr(dbg_addr1), .dbg_rdata(dbg_rdata1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Response monitors: pop one expectation per resp_valid, check cycle, data and error
  always @(negedge clk) begin
    if (resp_valid0) begin
      if (q0.size() == 0) chk("dut0_spurious_resp", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        chk("dut0_resp_cycle", 32'(cyc), 32'(e0.cyc));
        chk("dut0_resp_rdata", resp_rdata0, e0.rdata);
        chk("dut0_resp_err", 32'(resp_err0), 32'(e0.err));
      end
    end else begin
      chk("dut0_idle_rdata", resp_rdata0, 32'd0);
      chk("dut0_idle_err", 32'(resp_err0), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (resp_valid1) begin
      if (q1.size() == 0) chk("dut1_spurious_resp", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("dut1_resp_cycle", 32'(cyc), 32'(e1.cyc));
        chk("dut1_resp_rdata", resp_rdata1, e1.rdata);
        chk("dut1_resp_err", 32'(resp_err1), 32'(e1.err));
      end
    end else begin
      chk("dut1_idle_rdata", resp_rdata1, 32'd0);
      chk("dut1_idle_err", 32'(resp_err1), 32'd0);
    end
  end

  // Present one request to dut d, wait (bounded) for ready, and log the expected response
  task automatic issue(input bit d, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err,
                       input bit push, input bit now);
    int n = 0;
    if (!now) @(negedge clk);
    if (d) begin
      req_valid1 = 1'b1; req_we1 = we; req_funct31 = f3; req_addr1 = addr; req_wdata1 = wdata;
    end else begin
      req_valid0 = 1'b1; req_we0 = we; req_funct30 = f3; req_addr0 = addr; req_wdata0 = wdata;
    end
    while (!(d ? req_ready1 : req_ready0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(d ? req_ready1 : req_ready0)) begin
      chk("issue_ready_timeout", 32'd0, 32'd1);
    end else if (push) begin
      if (d) q1.push_back('{cyc + 1, exp_rd, exp_err});
      else   q0.push_back('{cyc + 2, exp_rd, exp_err});
    end
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      chk("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
      q0.delete();
      q1.delete();
    end
    @(negedge clk);
  endtask

  task automatic dbgchk(input bit d, input logic [4:0] a, input logic [31:0] req, input string nm);
    if (d) dbg_addr1 = a; else dbg_addr0 = a;
    #1;
    chk(nm, d ? dbg_rdata1 : dbg_rdata0, req);
  endtask

  initial begin
    rst_n = 1'b1;
    req_valid0 = 0; req_we0 = 0; req_funct30 = 0; req_addr0 = 0; req_wdata0 = 0; dbg_addr0 = 0;
    req_valid1 = 0; req_we1 = 0; req_funct31 = 0; req_addr1 = 0; req_wdata1 = 0; dbg_addr1 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_ready0", 32'(req_ready0), 32'd1);
    chk("reset_ready1", 32'(req_ready1), 32'd1);
    chk("reset_resp_valid0", 32'(resp_valid0), 32'd0);
    dbgchk(0, 5'd2, 32'h0, "reset_mem_word2");

    // Word store/load and ready timing
    issue(0, 1, 3'b010, 32'd8, 32'hDEADBEEF, 32'h0, 0, 1, 0);
    issue(0, 0, 3'b010, 32'd8, 32'h0, 32'hDEADBEEF, 0, 1, 0);
    @(negedge clk); chk("busy_ready_wait", 32'(req_ready0), 32'd0);
    @(negedge clk); chk("busy_ready_resp", 32'(req_ready0), 32'd0);
    @(negedge clk); chk("ready_after_resp", 32'(req_ready0), 32'd1);

    // Sub-word loads with sign/zero extension
    issue(0, 0, 3'b000, 32'd11, 32'h0, 32'hFFFFFFDE, 0, 1, 0);
    issue(0, 0, 3'b100, 32'd11, 32'h0, 32'h000000DE, 0, 1, 0);
    issue(0, 0, 3'b001, 32'd8,  32'h0, 32'hFFFFBEEF, 0, 1, 0);
    issue(0, 0, 3'b101, 32'd10, 32'h0, 32'h0000DEAD, 0, 1, 0);

    // Byte store merges into the word
    issue(0, 1, 3'b000, 32'd9, 32'h00000012, 32'h0, 0, 1, 0);
    issue(0, 0, 3'b010, 32'd8, 32'h0, 32'hDEAD12EF, 0, 1, 0);
    drain();
    dbgchk(0, 5'd2, 32'hDEAD12EF, "dbg_word2_after_sb");

    // Errored requests: misaligned, out of range, illegal funct3
    issue(0, 1, 3'b010, 32'd6,   32'h11223344, 32'h0, 1, 1, 0);
    issue(0, 0, 3'b001, 32'd3,   32'h0,        32'h0, 1, 1, 0);
    issue(0, 0, 3'b010, 32'd128, 32'h0,        32'h0, 1, 1, 0);
    issue(0, 1, 3'b000, 32'd128, 32'h000000AA, 32'h0, 1, 1, 0);
    issue(0, 0, 3'b011, 32'd0,   32'h0,        32'h0, 1, 1, 0);
    issue(0, 1, 3'b100, 32'd0,   32'h000000BB, 32'h0, 1, 1, 0);
    drain();
    dbgchk(0, 5'd1, 32'h0, "dbg_word1_no_write");
    dbgchk(0, 5'd0, 32'h0, "dbg_word0_no_wrap");
    dbgchk(0, 5'd2, 32'hDEAD12EF, "dbg_word2_unchanged");

    // LATENCY=1 instance, 64 bytes: store, range error, debug range
    issue(1, 1, 3'b010, 32'd16, 32'hCAFEF00D, 32'h0, 0, 1, 0);
    issue(1, 0, 3'b010, 32'd64, 32'h0, 32'h0, 1, 1, 0);
    drain();
    dbgchk(1, 5'd4,  32'hCAFEF00D, "dut1_dbg_word4");
    dbgchk(1, 5'd20, 32'h0, "dut1_dbg_out_of_range");

    // Continuous req_valid at LATENCY=1: an accept every second cycle
    @(negedge clk);
    req_valid1 = 1'b1; req_we1 = 1'b0; req_funct31 = 3'b010; req_addr1 = 32'd16;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      if (req_ready1) begin
        acc++;
        q1.push_back('{cyc + 1, 32'hCAFEF00D, 1'b0});
      end
      @(negedge clk);
    end
    req_valid1 = 1'b0;
    chk("dut1_accepts_in_8", 32'(acc), 32'd4);
    drain();

    // Reset during WAIT of a store aborts it
    issue(0, 1, 3'b010, 32'd0, 32'h00000055, 32'h0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    chk("ready_after_release", 32'(req_ready0), 32'd1);
    issue(0, 0, 3'b010, 32'd0, 32'h0, 32'h0, 0, 1, 1);
    drain();
    dbgchk(0, 5'd0, 32'h0, "abort_word0_zero");
    dbgchk(0, 5'd2, 32'h0, "reset_cleared_word2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 128, meaning byte capacity; it SHALL be a power of two, at least 8.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning request address width; only the low log2(DEPTH_BYTES) bits index the array.
REQ-003 SHALL have parameter LATENCY, default 2, meaning cycles from acceptance to response; legal range is 1..7.
REQ-004 SHALL have parameter DBG_AW, default 5, meaning debug word-address width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-high reset (asserted = 1).
REQ-007 SHALL have port req_valid, input, 1 bit: a request is present.
REQ-008 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-009 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-010 SHALL have port req_funct3, input, 3 bits: RV32 size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-011 SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-012 SHALL have port req_wdata, input, 32 bits: store data, LSB-aligned.
REQ-013 SHALL have port resp_valid, output, 1 bit: one-cycle response strobe.
REQ-014 SHALL have port resp_rdata, output, 32 bits: load result, sign- or zero-extended.
REQ-015 SHALL have port resp_err, output, 1 bit: misaligned, out-of-range or illegal funct3.
REQ-016 SHALL have port dbg_addr, input, DBG_AW bits: debug word index.
REQ-017 SHALL have port dbg_rdata, output, 32 bits: combinational little-endian word at byte 4*dbg_addr.

Function
REQ-018 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-019 IDLE SHALL assert req_ready=1; a request is accepted when req_valid && req_ready, capturing all req_* fields and moving to WAIT, or directly to RESP when LATENCY=1.
REQ-020 WAIT SHALL count a latency counter from 1 to LATENCY-1, then move to RESP; req_ready SHALL be 0 throughout WAIT and RESP.
REQ-021 RESP SHALL drive resp_valid=1 for exactly one cycle, then return to IDLE; back-to-back requests therefore issue at best every LATENCY+1 cycles.
REQ-022 Load data SHALL be read from the array on the RESP cycle, so a store accepted earlier is always visible.
REQ-023 Little-endian byte lanes: halfword uses addr[1]; byte uses addr[1:0].
REQ-024 B and H loads SHALL sign-extend; BU and HU loads SHALL zero-extend.
REQ-025 A store SHALL write only the addressed bytes, on the cycle of acceptance.
REQ-026 An error SHALL be flagged when any of these holds: H/HU with addr[0]=1; W with addr[1:0]!=0; addr >= DEPTH_BYTES; funct3 not in {000,001,010,100,101} (stores accept only 000/001/010).
REQ-027 On an errored request: no array write occurs, resp_rdata=0, resp_err=1, and timing is unchanged.
REQ-028 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.
REQ-029 When dbg_addr exceeds DEPTH_BYTES/4-1, dbg_rdata SHALL be 0.

Reset
REQ-030 rst_n=1 SHALL immediately force state IDLE, counter 0, req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_err=0, and all array bytes to 0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no response and no partial write.

Structure
REQ-032 A shared package mem_pkg SHALL hold the funct3 size enum, the FSM state typedef, and the LATENCY_MAX=7 constant.
REQ-033 A sub-module dmem_align SHALL provide purely combinational byte-lane alignment, extension, write-strobe generation and error decode.

Verification
REQ-034 With LATENCY=2: SW 0xDEADBEEF @8, then LW @8 -> resp_valid exactly 2 cycles after each accept; rdata=0xDEADBEEF; req_ready low for 2 cycles.
REQ-035 After SW 0xDEADBEEF @8: LB @11 -> 0xFFFFFFDE; LBU @11 -> 0x000000DE; LH @8 -> 0xFFFFBEEF; LHU @10 -> 0x0000DEAD.
REQ-036 After SW 0xDEADBEEF @8: SB 0x12 @9 -> LW @8 = 0xDEAD12EF, dbg_addr=2 -> dbg_rdata=0xDEAD12EF.
REQ-037 SW @6, LH @3 and LW @DEPTH_BYTES -> resp_err=1, rdata=0, memory unchanged per the debug port.
REQ-038 rst_n pulsed high during WAIT of SW 0x55 @0 -> no resp_valid; word 0 reads 0; the next request is accepted in the first cycle after release.
REQ-039 req_valid held high continuously with LATENCY=1 -> accepts every 2nd cycle, one resp_valid per accept.
